// File: rtl/operation_encoder.sv
// -----------------------------------------------------------------------------
// operation_encoder
//
// Purpose:
//   Converts decoded PS/2 keyboard events for one player into the movement
//   (h_code / v_code) and boost controls consumed by the physics engine.
//   It tracks which of the five bound keys are held. When both keys of an
//   axis are held, the one pressed most recently wins. Boost is rationed by
//   an energy meter. The meter drains one unit per energy tick while boosting
//   and recharges one unit per tick otherwise. Once the meter is fully
//   drained, boost stays locked out until the meter is full again.
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous, active-high reset
//   key_valid  in   1  one-cycle strobe: key_code / key_break valid
//   key_code   in   9  {extended flag, scan code}
//   key_break  in   1  1 = key released, 0 = key pressed (make)
//   active     in   1  1 = race running; 0 forces h_code/v_code/boost to 0
//   h_code     out  2  0 NIL, 1 LEFT, 2 RIGHT (registered)
//   v_code     out  2  0 NIL, 1 UP, 2 DOWN (registered)
//   boost      out  1  boost request (registered)
//   energy     out  7  current energy 0..ENERGY_MAX
//   lockout    out  1  1 = depleted, boost inhibited until energy is full
// -----------------------------------------------------------------------------
module operation_encoder #(
    parameter logic [8:0] KEY_UP     = 9'h01D,
    parameter logic [8:0] KEY_DOWN   = 9'h01B,
    parameter logic [8:0] KEY_LEFT   = 9'h01C,
    parameter logic [8:0] KEY_RIGHT  = 9'h023,
    parameter logic [8:0] KEY_BOOST  = 9'h029,
    parameter int         TICK_DIV   = 1000000,
    parameter int         ENERGY_MAX = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       key_break,
    input  logic       active,
    output logic [1:0] h_code,
    output logic [1:0] v_code,
    output logic       boost,
    output logic [6:0] energy,
    output logic       lockout
);

    // Index of each key in the held-flag vector.
    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_BOOST = 4;
    localparam int NKEYS   = 5;

    localparam logic [1:0] CODE_NIL   = 2'd0;
    localparam logic [1:0] CODE_LEFT  = 2'd1;
    localparam logic [1:0] CODE_RIGHT = 2'd2;
    localparam logic [1:0] CODE_UP    = 2'd1;
    localparam logic [1:0] CODE_DOWN  = 2'd2;

    localparam logic [NKEYS-1:0][8:0] KEY_TABLE =
        {KEY_BOOST, KEY_RIGHT, KEY_LEFT, KEY_DOWN, KEY_UP};

    localparam int         CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [6:0] EMAX     = 7'(ENERGY_MAX);

    // -------------------------------------------------------------------------
    // Key decode: one match line per bound key.
    // -------------------------------------------------------------------------
    logic [NKEYS-1:0] key_hit;

    generate
        for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key_match
            assign key_hit[gi] = key_valid && (key_code == KEY_TABLE[gi]);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [NKEYS-1:0] held_q,    held_d;
    logic             h_last_q,  h_last_d;   // 1 = RIGHT pressed last, 0 = LEFT
    logic             v_last_q,  v_last_d;   // 1 = DOWN pressed last, 0 = UP
    logic [1:0]       h_code_q,  h_code_d;
    logic [1:0]       v_code_q,  v_code_d;
    logic             boost_q,   boost_d;
    logic [6:0]       energy_q,  energy_d;
    logic             lockout_q, lockout_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic             tick;
    logic [1:0]       h_res;
    logic [1:0]       v_res;

    // -------------------------------------------------------------------------
    // Held / last-pressed flags.
    // A make only claims the axis when the key was not already down, so
    // typematic repeats of a held key cannot steal priority back.
    // -------------------------------------------------------------------------
    always_comb begin
        held_d   = held_q;
        h_last_d = h_last_q;
        v_last_d = v_last_q;

        for (int i = 0; i < NKEYS; i++) begin
            if (key_hit[i]) begin
                held_d[i] = ~key_break;
            end
        end

        if (!key_break) begin
            if (key_hit[K_UP] && !held_q[K_UP]) begin
                v_last_d = 1'b0;
            end
            if (key_hit[K_DOWN] && !held_q[K_DOWN]) begin
                v_last_d = 1'b1;
            end
            if (key_hit[K_LEFT] && !held_q[K_LEFT]) begin
                h_last_d = 1'b0;
            end
            if (key_hit[K_RIGHT] && !held_q[K_RIGHT]) begin
                h_last_d = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Axis resolution from the registered flags. When the winner is released,
    // only the opposite key remains held and takes over automatically.
    // -------------------------------------------------------------------------
    always_comb begin
        h_res = CODE_NIL;
        case ({held_q[K_RIGHT], held_q[K_LEFT]})
            2'b01:   h_res = CODE_LEFT;
            2'b10:   h_res = CODE_RIGHT;
            2'b11:   h_res = h_last_q ? CODE_RIGHT : CODE_LEFT;
            default: h_res = CODE_NIL;
        endcase
    end

    always_comb begin
        v_res = CODE_NIL;
        case ({held_q[K_DOWN], held_q[K_UP]})
            2'b01:   v_res = CODE_UP;
            2'b10:   v_res = CODE_DOWN;
            2'b11:   v_res = v_last_q ? CODE_DOWN : CODE_UP;
            default: v_res = CODE_NIL;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered control outputs. With active low the outputs are forced to
    // zero, but the flags and the energy meter keep running underneath.
    // -------------------------------------------------------------------------
    always_comb begin
        h_code_d = active ? h_res : CODE_NIL;
        v_code_d = active ? v_res : CODE_NIL;
        boost_d  = active && held_q[K_BOOST] && !lockout_q && (energy_q != 7'd0);
    end

    // -------------------------------------------------------------------------
    // Energy meter. The drain/recharge decision uses the boost value that was
    // registered before the tick edge. A boost release arriving on the tick
    // edge therefore still costs that tick.
    // -------------------------------------------------------------------------
    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
        energy_d  = energy_q;
        lockout_d = lockout_q;

        if (tick) begin
            if (boost_q) begin
                if (energy_q != 7'd0) begin
                    energy_d = energy_q - 7'd1;
                end
                // Reaching (or sitting at) zero latches the lockout.
                if (energy_q <= 7'd1) begin
                    lockout_d = 1'b1;
                end
            end else begin
                if (energy_q < EMAX) begin
                    energy_d = energy_q + 7'd1;
                end
                // Lockout is released only once the meter is full again.
                if (energy_q >= EMAX - 7'd1) begin
                    lockout_d = 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q    <= '0;
            h_last_q  <= 1'b0;
            v_last_q  <= 1'b0;
            h_code_q  <= CODE_NIL;
            v_code_q  <= CODE_NIL;
            boost_q   <= 1'b0;
            energy_q  <= EMAX;
            lockout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            held_q    <= held_d;
            h_last_q  <= h_last_d;
            v_last_q  <= v_last_d;
            h_code_q  <= h_code_d;
            v_code_q  <= v_code_d;
            boost_q   <= boost_d;
            energy_q  <= energy_d;
            lockout_q <= lockout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign h_code  = h_code_q;
    assign v_code  = v_code_q;
    assign boost   = boost_q;
    assign energy  = energy_q;
    assign lockout = lockout_q;

endmodule

// File: tb/tb_operation_encoder.sv
// -----------------------------------------------------------------------------
// tb_operation_encoder
//
// Scoreboard bench for operation_encoder (TICK_DIV=4, ENERGY_MAX=5).
// The stimulus process queues the expected output state for a given cycle,
// counted in clock edges since the last reset edge. The monitor process pops
// and compares that state on the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_operation_encoder;

    localparam logic [8:0] KW  = 9'h01D;
    localparam logic [8:0] KS  = 9'h01B;
    localparam logic [8:0] KA  = 9'h01C;
    localparam logic [8:0] KD  = 9'h023;
    localparam logic [8:0] KSP = 9'h029;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [8:0] key_code = 9'h000;
    logic       key_break = 1'b0;
    logic       active = 1'b1;
    logic [1:0] h_code;
    logic [1:0] v_code;
    logic       boost;
    logic [6:0] energy;
    logic       lockout;

    always #5 clk = ~clk;

    operation_encoder #(
        .TICK_DIV   (4),
        .ENERGY_MAX (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .key_break (key_break),
        .active    (active),
        .h_code    (h_code),
        .v_code    (v_code),
        .boost     (boost),
        .energy    (energy),
        .lockout   (lockout)
    );

    typedef struct {
        int         due;
        string      name;
        logic [1:0] h;
        logic [1:0] v;
        logic       b;
        logic [6:0] e;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // Edge counter: 0 on the reset edge, incremented on every later edge.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Monitor / scoreboard checker.
    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            x = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: not checked at cyc %0d (now %0d)", x.name, x.due, cyc);
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            x = sb.pop_front();
            checks++;
            if ({h_code, v_code, boost, energy, lockout} !== {x.h, x.v, x.b, x.e, x.l}) begin
                failures++;
                $display("FAIL %s @cyc %0d: got h=%0d v=%0d b=%0d e=%0d l=%0d, want h=%0d v=%0d b=%0d e=%0d l=%0d",
                         x.name, cyc, h_code, v_code, boost, energy, lockout,
                         x.h, x.v, x.b, x.e, x.l);
            end else begin
                $display("ok   %s @cyc %0d: h=%0d v=%0d b=%0d e=%0d l=%0d",
                         x.name, cyc, h_code, v_code, boost, energy, lockout);
            end
        end
    end

    task automatic want(input string name, input int due, input logic [1:0] h,
                        input logic [1:0] v, input logic b, input logic [6:0] e,
                        input logic l);
        exp_t x;
        x.due  = due;
        x.name = name;
        x.h    = h;
        x.v    = v;
        x.b    = b;
        x.e    = e;
        x.l    = l;
        sb.push_back(x);
    endtask

    // Wait until the falling edge of cycle c.
    task automatic at(input int c);
        if (cyc > c) begin
            $display("FAIL schedule: cyc %0d already past %0d", cyc, c);
            $fatal(1, "schedule overrun");
        end
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input logic [8:0] code, input logic brk);
        key_code  = code;
        key_break = brk;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL drain: %0d expectations never checked", sb.size());
                $fatal(1, "scoreboard drain timeout");
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        do_reset();

        // ---- Segment A: key tracking (energy stays full) -------------------
        want("reset",        1, 2'd0, 2'd0, 1'b0, 7'd5, 1'b0);
        want("makeD",        3, 2'd2, 2'd0, 1'b0, 7'd5, 1'b0);
        want("breakD_lat",   4, 2'd2, 2'd0, 1'b0, 7'd5, 1'b0);
        want("breakD",       5, 2'd0, 2'd0, 1'b0, 7'd5, 1'b0);
        want("makeA",        8, 2'd1, 2'd0, 1'b0, 7'd5, 1'b0);
        want("A+D_last",    10, 2'd2, 2'd0, 1'b0, 7'd5, 1'b0);
        want("relD_Awins",  12, 2'd1, 2'd0, 1'b0, 7'd5, 1'b0);
        want("relA",        14, 2'd0, 2'd0, 1'b0, 7'd5, 1'b0);
        want("makeW",       18, 2'd0, 2'd1, 1'b0, 7'd5, 1'b0);
        want("W+S_last",    20, 2'd0, 2'd2, 1'b0, 7'd5, 1'b0);
        want("repeatW",     22, 2'd0, 2'd2, 1'b0, 7'd5, 1'b0);
        want("relS",        24, 2'd0, 2'd1, 1'b0, 7'd5, 1'b0);
        want("relW",        26, 2'd0, 2'd0, 1'b0, 7'd5, 1'b0);

        at(1);  pulse(KD, 1'b0);
        at(3);  pulse(KD, 1'b1);
        at(6);  pulse(KA, 1'b0);
        at(8);  pulse(KD, 1'b0);
        at(10); pulse(KD, 1'b1);
        at(12); pulse(KA, 1'b1);
        at(16); pulse(KW, 1'b0);
        at(18); pulse(KS, 1'b0);
        at(20); pulse(KW, 1'b0);
        at(22); pulse(KS, 1'b1);
        at(24); pulse(KW, 1'b1);
        drain();
        do_reset();

        // ---- Segment B: energy drain/lockout/recharge, then active gating --
        // Energy ticks land on edges 4, 8, 12, ... after the reset edge.
        want("boost_on",     3, 2'd0, 2'd0, 1'b1, 7'd5, 1'b0);
        want("tick1",        4, 2'd0, 2'd1, 1'b1, 7'd4, 1'b0);
        want("between",      7, 2'd0, 2'd1, 1'b1, 7'd4, 1'b0);
        want("tick2",        8, 2'd0, 2'd1, 1'b1, 7'd3, 1'b0);
        want("e1",          19, 2'd0, 2'd1, 1'b1, 7'd1, 1'b0);
        want("e0_lock",     20, 2'd0, 2'd1, 1'b1, 7'd0, 1'b1);
        want("boost_drop",  21, 2'd0, 2'd1, 1'b0, 7'd0, 1'b1);
        want("recharge1",   24, 2'd0, 2'd1, 1'b0, 7'd1, 1'b1);
        want("recharge4",   39, 2'd0, 2'd1, 1'b0, 7'd4, 1'b1);
        want("full_unlock", 40, 2'd0, 2'd1, 1'b0, 7'd5, 1'b0);
        want("reboost",     41, 2'd0, 2'd1, 1'b1, 7'd5, 1'b0);
        want("redrain",     44, 2'd0, 2'd1, 1'b1, 7'd4, 1'b0);
        want("relSpace",    47, 2'd0, 2'd1, 1'b0, 7'd4, 1'b0);
        want("recharge_mx", 48, 2'd0, 2'd1, 1'b0, 7'd5, 1'b0);
        want("rel_on_tick", 52, 2'd0, 2'd1, 1'b1, 7'd4, 1'b0);
        want("rel_after",   53, 2'd0, 2'd1, 1'b0, 7'd4, 1'b0);
        want("rel_rechg",   56, 2'd0, 2'd1, 1'b0, 7'd5, 1'b0);
        want("relW2",       59, 2'd0, 2'd0, 1'b0, 7'd5, 1'b0);
        want("D+boost",     62, 2'd2, 2'd0, 1'b0, 7'd5, 1'b0);
        want("D+boost_b",   63, 2'd2, 2'd0, 1'b1, 7'd5, 1'b0);
        want("drain68",     68, 2'd2, 2'd0, 1'b1, 7'd3, 1'b0);
        want("pre_inact",   69, 2'd2, 2'd0, 1'b1, 7'd3, 1'b0);
        want("inactive",    70, 2'd0, 2'd0, 1'b0, 7'd3, 1'b0);
        want("inact_rch1",  72, 2'd0, 2'd0, 1'b0, 7'd4, 1'b0);
        want("inact_rch2",  76, 2'd0, 2'd0, 1'b0, 7'd5, 1'b0);
        want("inact_hold",  77, 2'd0, 2'd0, 1'b0, 7'd5, 1'b0);
        want("reactive",    78, 2'd2, 2'd0, 1'b1, 7'd5, 1'b0);
        want("react_drain", 80, 2'd2, 2'd0, 1'b1, 7'd4, 1'b0);

        at(1);  pulse(KSP, 1'b0);
        at(2);  pulse(KW, 1'b0);
        at(45); pulse(KSP, 1'b1);
        at(49); pulse(KSP, 1'b0);
        at(51); pulse(KSP, 1'b1);
        at(57); pulse(KW, 1'b1);
        at(60); pulse(KD, 1'b0);
        at(61); pulse(KSP, 1'b0);
        at(69); active = 1'b0;
        at(77); active = 1'b1;
        drain();

        // ---- Segment C: reset mid-boost, unrecognised and extended codes ---
        do_reset();
        want("rst_midboost", 1, 2'd0, 2'd0, 1'b0, 7'd5, 1'b0);
        want("unknown_code", 4, 2'd0, 2'd0, 1'b0, 7'd5, 1'b0);
        want("remake_space", 7, 2'd0, 2'd0, 1'b1, 7'd5, 1'b0);
        want("ext_code_W",  10, 2'd0, 2'd0, 1'b1, 7'd4, 1'b0);

        at(2);  pulse(9'h015, 1'b0);
        at(5);  pulse(KSP, 1'b0);
        at(8);  pulse(9'h11D, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
